i2s_tx: RTL
===========

// Module: i2s_tx
// PURPOSE
//  I2S (Philips) transmitter: serialises stereo PCM sample pairs onto ws_o/sdata_o, bit-compatible with I2Srx.
//  Sits downstream of the effects/async-FIFO read side; drives codec DAC or loops back into I2Srx for test.
//  Runs entirely in the bit-clock domain; one-deep holding register decouples the sample handshake from frame timing.
// PARAMETERS
//  WIDTH  16  sample bits per channel, MSB first (>=2)
//  SLOT   16  sclk cycles per channel slot (>=WIDTH); frame = 2*SLOT cycles
// PORTS
//  sclk_i          in   1      bit clock; all state updates on FALLING edge (receiver samples on rising)
//  rst_n_i         in   1      async active-low reset
//  en_i            in   1      run enable
//  leftChan_i      in   WIDTH  left sample
//  rightChan_i     in   WIDTH  right sample
//  sample_valid_i  in   1      L/R pair valid
//  sample_ready_o  out  1      = !holdFull (combinational)
//  ws_o            out  1      word select, 0=left, 1=right (registered)
//  sdata_o         out  1      serial data (registered)
//  frameStart_o    out  1      1-cycle pulse while left MSB is on sdata_o
//  underrun_o      out  1      1-cycle pulse at frame load with hold empty
//  underrunCnt_o   out  16     saturating underrun count
// BEHAVIOUR
//  Reset: cnt=2*SLOT-1, holdFull=0 (sample_ready_o=1), ws_o=0, sdata_o=0, frameStart_o=0, underrun_o=0,
//   underrunCnt_o=0, shift regs=0, lastL/lastR=0. Reset mid-frame aborts frame immediately.
//  Handshake: pair accepted on edge where valid&&ready; captured into hold, holdFull<=1. One pair max buffered.
//  Frame counter cnt: 0..2*SLOT-1, wraps to 0; advances every edge while en_i=1.
//  Output during cycle with counter value k (registered, one-cycle I2S delay built in):
//   ws_o=1 for k in [SLOT-1, 2*SLOT-2], else 0 -> ws toggles one cycle before each MSB.
//   sdata_o = left[WIDTH-1-k] for k<WIDTH; right[WIDTH-1-(k-SLOT)] for SLOT<=k<SLOT+WIDTH; else 0.
//  Frame load at edge leaving k=2*SLOT-1: if holdFull -> shift regs<=hold, lastL/lastR<=hold, holdFull<=0.
//   If hold empty -> underrun: underrun_o=1 next cycle, underrunCnt_o+1 (saturate 0xFFFF), frame data per CONFIGURATION.
//  Simultaneous accept + load while hold empty: accepted pair goes to hold (no bypass); current frame underruns.
//   While holdFull, ready=0 so accept and load never collide in hold.
//  frameStart_o high exactly in cycle k=0.
//  en_i=0: cnt forced to 2*SLOT-1, ws_o=0, sdata_o=0, no underrun counted; handshake still accepts into hold.
//   en_i 0->1: first edge performs frame load; left MSB appears that cycle. Disable mid-frame truncates frame.
//  Latency: pair accepted while idle-and-empty appears at next frame boundary (<= 2*SLOT+1 cycles).
// CONFIGURATION
//  I2S_TX_UNDERRUN_REPEAT_EN defined: underrun frame retransmits lastL/lastR (hold-last-sample).
//  Not defined: underrun frame transmits all-zero L and R (mute). Pulse/counter identical in both.
// TESTING (WIDTH=16, SLOT=16 unless noted)
//  1 Reset, push L=0xA5C3 R=0x8001, en_i=1 -> ws_o falls 1 cycle before left MSB; sdata bits 1010_0101_1100_0011
//    then 1000_0000_0000_0001; frameStart_o once; looped into I2Srx -> leftChan_o=0xA5C3, rightChan_o=0x8001.
//  2 Continuous valid stream of 4 pairs -> ready drops after each accept, reasserts at each load; no underrun,
//    4 consecutive gapless frames, underrunCnt_o=0.
//  3 One pair then starve 3 frames -> underrun_o 3 pulses, underrunCnt_o=3; sdata all zero (macro off)
//    or repeats 0xA5C3/0x8001 (macro on).
//  4 WIDTH=16 SLOT=32 -> ws period 64 cycles, bits 16..31 of each slot zero, receiver still decodes MSB-aligned.
//  5 Valid asserted exactly on load edge with hold empty -> that frame underruns, next frame carries the pair.
//  6 rst_n_i pulsed low mid-right-slot, then en_i low 5 cycles -> outputs 0 immediately, ready=1, counters 0;
//    restart produces clean frame 1 behaviour.

Source files
------------

// File: rtl/i2s_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_tx : Philips I2S transmitter with one-deep sample holding register.     |
// | Optional: I2S_TX_UNDERRUN_REPEAT_EN repeats the last pair on underrun.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module i2s_tx #(
  parameter int WIDTH = 16,
  parameter int SLOT  = 16
) (
  input  logic             sclk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] leftChan_i,
  input  logic [WIDTH-1:0] rightChan_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  output logic             ws_o,
  output logic             sdata_o,
  output logic             frameStart_o,
  output logic             underrun_o,
  output logic [15:0]      underrunCnt_o
);

  localparam int FRAME = 2 * SLOT;
  localparam int CW    = $clog2(FRAME);

  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  // One extra bit so SLOT+WIDTH can be represented when WIDTH == SLOT.
  localparam logic [CW:0]   WS_LO    = (CW+1)'(SLOT - 1);
  localparam logic [CW:0]   WS_HI    = (CW+1)'(FRAME - 2);
  localparam logic [CW:0]   L_END    = (CW+1)'(WIDTH);
  localparam logic [CW:0]   R_BEGIN  = (CW+1)'(SLOT);
  localparam logic [CW:0]   R_END    = (CW+1)'(SLOT + WIDTH);
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic [15:0]      ur_cnt_q, ur_cnt_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [WIDTH-1:0] last_l_q, last_l_d;
  logic [WIDTH-1:0] last_r_q, last_r_d;
`endif

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] new_l;
  logic [WIDTH-1:0] new_r;
  logic [CW:0]      cnt_ext;

  assign accept = sample_valid_i && !hold_full_q;
  assign load   = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d       = cnt_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    sh_l_d      = sh_l_q;
    sh_r_d      = sh_r_q;
    ws_d        = 1'b0;
    sdata_d     = 1'b0;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    ur_cnt_d    = ur_cnt_q;
    new_l       = '0;
    new_r       = '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;
`endif

    if (!en_i) begin
      cnt_d = CNT_LAST;
    end else if (load) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    cnt_ext = {1'b0, cnt_d};

    // Load empties the hold; an accept on the same edge can only happen
    // when the hold was already empty, so the pair lands in hold, not the frame.
    if (load && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_l_d    = leftChan_i;
      hold_r_d    = rightChan_i;
      hold_full_d = 1'b1;
    end

    if (hold_full_q) begin
      new_l = hold_l_q;
      new_r = hold_r_q;
    end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      new_l = last_l_q;
      new_r = last_r_q;
`else
      new_l = '0;
      new_r = '0;
`endif
    end

    if (load) begin
      fs_d = 1'b1;
      ur_d = !hold_full_q;
      if (!hold_full_q && (ur_cnt_q != CNT_MAX)) begin
        ur_cnt_d = ur_cnt_q + 16'd1;
      end
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_l_d = new_l;
      last_r_d = new_r;
`endif
    end

    ws_d = en_i && (cnt_ext >= WS_LO) && (cnt_ext <= WS_HI);

    // Outputs are computed for the counter value being entered, which gives
    // the one-bit I2S delay between ws and the MSB for free.
    if (load) begin
      sdata_d = new_l[WIDTH-1];
      sh_l_d  = {new_l[WIDTH-2:0], 1'b0};
      sh_r_d  = new_r;
    end else if (en_i) begin
      if (cnt_ext < L_END) begin
        sdata_d = sh_l_q[WIDTH-1];
        sh_l_d  = {sh_l_q[WIDTH-2:0], 1'b0};
      end else if ((cnt_ext >= R_BEGIN) && (cnt_ext < R_END)) begin
        sdata_d = sh_r_q[WIDTH-1];
        sh_r_d  = {sh_r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= CNT_LAST;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
      ws_q        <= 1'b0;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      ur_cnt_q    <= '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_l_q    <= '0;
      last_r_q    <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      sh_l_q      <= sh_l_d;
      sh_r_q      <= sh_r_d;
      ws_q        <= ws_d;
      sdata_q     <= sdata_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      ur_cnt_q    <= ur_cnt_d;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
`endif
    end
  end

  assign sample_ready_o = !hold_full_q;
  assign ws_o           = ws_q;
  assign sdata_o        = sdata_q;
  assign frameStart_o   = fs_q;
  assign underrun_o     = ur_q;
  assign underrunCnt_o  = ur_cnt_q;

endmodule
`default_nettype wire
